// File: rtl/pcap_replay_ts_pacer_pkg.sv
// Shared types and constants for the pcap replay timestamp pacer.
// State encoding and timestamp field placement within tuser.
package pcap_replay_ts_pacer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_e;

  localparam int TS_LSB        = 32;
  localparam int TS_WIDTH      = 32;
  localparam int ELAPSED_WIDTH = 40;

endpackage

// File: rtl/pcap_replay_ts_pacer.sv
// Replays a captured packet stream at its recorded inter-packet spacing.
// Strips the capture timestamp from tuser on the way out.
module pcap_replay_ts_pacer
  import pcap_replay_ts_pacer_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CYCLES_PER_US        = 200
) (
  input  logic                              axis_aclk,
  input  logic                              axis_reset,
  input  logic                              replay_en,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       pkt_cnt,
  output logic [31:0]                       late_cnt
);

  localparam logic [ELAPSED_WIDTH-1:0] CPU_W =
    ELAPSED_WIDTH'(CYCLES_PER_US);

  state_e                     state_q, state_d;
  logic                       first_q, first_d;
  logic                       mid_q, mid_d;
  logic [ELAPSED_WIDTH-1:0]   elapsed_q, elapsed_d;
  logic [ELAPSED_WIDTH-1:0]   target_q, target_d;
  logic [TS_WIDTH-1:0]        ts_prev_q, ts_prev_d;
  logic [TS_WIDTH-1:0]        delta_q, delta_d;
  logic [31:0]                pkt_q, pkt_d;
  logic [31:0]                late_q, late_d;

  logic [TS_WIDTH-1:0]        ts_in;
  logic [ELAPSED_WIDTH-1:0]   elapsed_inc;
  logic [ELAPSED_WIDTH-1:0]   calc_target;
  logic                       send;
  logic                       beat_hs;
  logic                       first_hs;
  logic                       last_hs;
  logic                       unused_tuser;

  assign ts_in = s_axis_tuser[TS_LSB +: TS_WIDTH];
  assign unused_tuser =
    ^s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:TS_LSB+TS_WIDTH];

  assign send     = (state_q == SEND);
  assign beat_hs  = s_axis_tvalid & s_axis_tready;
  assign first_hs = beat_hs & ~mid_q;
  assign last_hs  = beat_hs & s_axis_tlast;

  assign elapsed_inc = (&elapsed_q) ? elapsed_q
                                    : elapsed_q + 1'b1;
  assign calc_target = ELAPSED_WIDTH'(delta_q) * CPU_W;

  assign s_axis_tready = m_axis_tready & send;
  assign m_axis_tvalid = s_axis_tvalid & send;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast & send;

  always_comb begin
    m_axis_tuser = '0;
    m_axis_tuser[TS_LSB-1:0] = s_axis_tuser[TS_LSB-1:0];
  end

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    mid_d     = mid_q;
    elapsed_d = elapsed_inc;
    target_d  = target_q;
    ts_prev_d = ts_prev_q;
    delta_d   = delta_q;
    pkt_d     = pkt_q;
    late_d    = late_q;
    unique case (state_q)
      IDLE: begin
        if (s_axis_tvalid && replay_en) begin
          if (first_q || ts_in == '0) begin
            state_d = SEND;
          end else begin
            delta_d = ts_in - ts_prev_q;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        target_d = calc_target;
        if (elapsed_q >= calc_target) begin
          late_d = late_q + 32'd1;
        end
        state_d = WAIT;
      end
      WAIT: begin
        // Enter SEND in the cycle elapsed reaches target
        if (elapsed_inc >= target_q) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (first_hs) begin
          if (ts_in != '0) begin
            ts_prev_d = ts_in;
          end
          first_d   = 1'b0;
          elapsed_d = ELAPSED_WIDTH'(1);
        end
        if (beat_hs) begin
          mid_d = ~s_axis_tlast;
        end
        if (last_hs) begin
          pkt_d   = pkt_q + 32'd1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q   <= IDLE;
      first_q   <= 1'b1;
      mid_q     <= 1'b0;
      elapsed_q <= '0;
      target_q  <= '0;
      ts_prev_q <= '0;
      delta_q   <= '0;
      pkt_q     <= '0;
      late_q    <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      mid_q     <= mid_d;
      elapsed_q <= elapsed_d;
      target_q  <= target_d;
      ts_prev_q <= ts_prev_d;
      delta_q   <= delta_d;
      pkt_q     <= pkt_d;
      late_q    <= late_d;
    end
  end

  assign pkt_cnt  = pkt_q;
  assign late_cnt = late_q;

endmodule

// File: tb/tb_pcap_replay_ts_pacer.sv
// Bench for pcap_replay_ts_pacer: directed scenarios plus randomized
// packets against a cycle-level pacing model.
module tb_pcap_replay_ts_pacer;

  localparam int CPU   = 200;
  localparam int LIMIT = 3000;

  logic         clk = 1'b0;
  logic         axis_reset;
  logic         replay_en;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic [31:0]  pkt_cnt;
  logic [31:0]  late_cnt;

  pcap_replay_ts_pacer #(.CYCLES_PER_US(CPU)) u_dut (
    .axis_aclk     (clk),
    .axis_reset    (axis_reset),
    .replay_en     (replay_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_cnt       (pkt_cnt),
    .late_cnt      (late_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0;
  int nchk  = 0;

  logic [255:0] exp_d[$];
  logic [31:0]  exp_u[$];
  bit           exp_l[$];
  logic [255:0] got_d[$];
  logic [127:0] got_u[$];
  bit           got_l[$];
  int           dep_q[$];
  logic [127:0] fu_q[$];
  bit           mon_mid = 1'b0;

  always @(negedge clk) begin
    if (axis_reset) begin
      mon_mid = 1'b0;
    end else if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      if (!mon_mid) begin
        dep_q.push_back(cyc);
        fu_q.push_back(m_axis_tuser);
      end
      got_d.push_back(m_axis_tdata);
      got_u.push_back(m_axis_tuser);
      got_l.push_back(m_axis_tlast);
      mon_mid = !m_axis_tlast;
    end
  end

  // Pacing model: departure cycle of each first beat from spacing rules
  bit          m_first;
  logic [31:0] m_tsprev;
  longint      m_prevdep;
  int          m_pkts;
  int          m_late;

  function automatic void mdl_reset();
    m_first = 1'b1;
    m_tsprev = '0;
    m_prevdep = 0;
    m_pkts = 0;
    m_late = 0;
  endfunction

  function automatic longint predict(input logic [31:0] ts,
                                     input longint p);
    longint d, tgt;
    logic [31:0] delta;
    if (m_first || ts == 32'h0) begin
      d = p + 1;
    end else begin
      delta = ts - m_tsprev;
      tgt = longint'(delta) * CPU;
      if (p + 1 - m_prevdep >= tgt) m_late++;
      d = (p + 3 > m_prevdep + tgt) ? p + 3 : m_prevdep + tgt;
    end
    m_first = 1'b0;
    if (ts != 32'h0) m_tsprev = ts;
    m_prevdep = d;
    m_pkts++;
    return d;
  endfunction

  task automatic flush();
    exp_d.delete(); exp_u.delete(); exp_l.delete();
    got_d.delete(); got_u.delete(); got_l.delete();
    dep_q.delete(); fu_q.delete();
  endtask

  task automatic do_reset();
    axis_reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    @(posedge clk); #1;
    axis_reset = 1'b0;
    mdl_reset();
    flush();
  endtask

  function automatic int pop_dep();
    if (dep_q.size() == 0) return -1;
    return dep_q.pop_front();
  endfunction

  task automatic send_pkt(input logic [31:0] ts, input int nb,
                          input int gap, output int p);
    int w;
    bit hs;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
    p = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 8; k++) s_axis_tdata[k*32 +: 32] = $urandom;
      s_axis_tkeep = $urandom;
      s_axis_tuser = {$urandom, $urandom,
                      (b == 0) ? ts : 32'($urandom), 32'($urandom)};
      s_axis_tlast = (b == nb - 1);
      s_axis_tvalid = 1'b1;
      exp_d.push_back(s_axis_tdata);
      exp_u.push_back(s_axis_tuser[31:0]);
      exp_l.push_back(s_axis_tlast);
      w = 0;
      hs = 1'b0;
      while (!hs && w < LIMIT) begin
        @(negedge clk);
        hs = (s_axis_tready === 1'b1);
        @(posedge clk); #1;
        w++;
      end
      if (!hs) begin
        nchk++;
        $display("FAIL send_timeout beat %0d waited %0d cycles, limit %0d",
                 b, w, LIMIT);
        do_reset();
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic test_reset();
    axis_reset = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast = 1'b1;
    m_axis_tready = 1'b1;
    replay_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nchk++; if (s_axis_tready !== 1'b0)
      $display("FAIL rst_s_tready got %b exp 0", s_axis_tready); else npass++;
    nchk++; if (m_axis_tvalid !== 1'b0)
      $display("FAIL rst_m_tvalid got %b exp 0", m_axis_tvalid); else npass++;
    nchk++; if (m_axis_tlast !== 1'b0)
      $display("FAIL rst_m_tlast got %b exp 0", m_axis_tlast); else npass++;
    nchk++; if (pkt_cnt !== 32'd0)
      $display("FAIL rst_pkt_cnt got %0d exp 0", pkt_cnt); else npass++;
    nchk++; if (late_cnt !== 32'd0)
      $display("FAIL rst_late_cnt got %0d exp 0", late_cnt); else npass++;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    @(posedge clk); #1;
    axis_reset = 1'b0;
    mdl_reset();
    flush();
  endtask

  task automatic test_paced();
    logic [31:0] tsv[3];
    longint e[3];
    int g[3];
    int p;
    tsv[0] = 32'h100; tsv[1] = 32'h101; tsv[2] = 32'h103;
    replay_en = 1'b0;
    fork
      send_pkt(tsv[0], 2, 0, p);
      begin
        repeat (20) begin @(posedge clk); #1; end
        nchk++; if (dep_q.size() != 0)
          $display("FAIL replay_en_hold got %0d departures exp 0",
                   dep_q.size()); else npass++;
        replay_en = 1'b1;
      end
    join
    e[0] = predict(tsv[0], p + 20);
    for (int i = 1; i < 3; i++) begin
      send_pkt(tsv[i], 2, 0, p);
      e[i] = predict(tsv[i], p);
    end
    for (int i = 0; i < 3; i++) begin
      g[i] = pop_dep();
      nchk++; if (longint'(g[i]) !== e[i])
        $display("FAIL paced_dep%0d got %0d exp %0d", i, g[i], e[i]);
      else npass++;
      nchk++;
      if (fu_q.size() == 0 || fu_q[0][127:32] !== 96'h0)
        $display("FAIL paced_tuser_strip%0d got %h exp 0", i,
                 (fu_q.size() != 0) ? fu_q[0][127:32] : 96'hx);
      else npass++;
      if (fu_q.size() != 0) void'(fu_q.pop_front());
    end
    nchk++; if (g[2] - g[0] !== 3 * CPU)
      $display("FAIL paced_span got %0d exp %0d", g[2] - g[0], 3 * CPU);
    else npass++;
    nchk++; if (pkt_cnt !== 32'd3)
      $display("FAIL paced_pkt_cnt got %0d exp 3", pkt_cnt); else npass++;
    flush();
  endtask

  task automatic test_zero_ts();
    int p0, p1, d0, d1;
    longint e1;
    send_pkt(32'h0, 1, 5, p0);
    void'(predict(32'h0, p0));
    send_pkt(32'h105, 1, 0, p1);
    e1 = predict(32'h105, p1);
    d0 = pop_dep();
    d1 = pop_dep();
    nchk++; if (d0 !== p0 + 1)
      $display("FAIL zero_ts_dep got %0d exp %0d", d0, p0 + 1); else npass++;
    nchk++; if (longint'(d1) !== e1)
      $display("FAIL zero_ts_next_dep got %0d exp %0d", d1, e1); else npass++;
    flush();
  endtask

  task automatic test_late();
    int p, d;
    longint e;
    send_pkt(m_tsprev + 32'd1, 2, 1000, p);
    e = predict(m_tsprev + 32'd1, p);
    d = pop_dep();
    nchk++; if (late_cnt !== 32'(m_late) || m_late != 1)
      $display("FAIL late_cnt got %0d exp 1", late_cnt); else npass++;
    nchk++; if (d - p > 3 || d <= p)
      $display("FAIL late_latency got %0d exp 1..3", d - p); else npass++;
    nchk++; if (longint'(d) !== e)
      $display("FAIL late_dep got %0d exp %0d", d, e); else npass++;
    flush();
  endtask

  task automatic test_backpressure();
    int p;
    bit bp;
    logic [31:0] pc0;
    bit ok;
    pc0 = pkt_cnt;
    bp = 1'b1;
    fork
      begin send_pkt(32'h0, 4, 3, p); bp = 1'b0; end
      begin
        while (bp) begin @(posedge clk); #1; m_axis_tready = ~m_axis_tready; end
      end
    join
    m_axis_tready = 1'b1;
    m_pkts++;
    nchk++; if (got_d.size() != 4)
      $display("FAIL bp_beats got %0d exp 4", got_d.size()); else npass++;
    for (int i = 0; i < 4; i++) begin
      ok = (got_d.size() > i) && got_d[i] === exp_d[i] &&
           got_u[i] === {96'h0, exp_u[i]} && got_l[i] === exp_l[i];
      nchk++; if (!ok)
        $display("FAIL bp_beat%0d got %h exp %h", i,
                 (got_d.size() > i) ? got_d[i] : 256'hx, exp_d[i]);
      else npass++;
    end
    nchk++; if (pkt_cnt !== pc0 + 32'd1)
      $display("FAIL bp_pkt_cnt got %0d exp %0d", pkt_cnt, pc0 + 1);
    else npass++;
    flush();
  endtask

  task automatic test_reset_wait();
    int p, d;
    s_axis_tdata = '0;
    s_axis_tkeep = '1;
    s_axis_tuser = {64'h0, m_tsprev + 32'd100, 32'h40};
    s_axis_tlast = 1'b1;
    s_axis_tvalid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    nchk++; if (m_axis_tvalid !== 1'b0)
      $display("FAIL rw_waiting got tvalid %b exp 0", m_axis_tvalid);
    else npass++;
    axis_reset = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    axis_reset = 1'b0;
    nchk++; if (pkt_cnt !== 32'd0 || late_cnt !== 32'd0)
      $display("FAIL rw_counters got %0d/%0d exp 0/0", pkt_cnt, late_cnt);
    else npass++;
    mdl_reset();
    flush();
    send_pkt(32'h500, 2, 0, p);
    void'(predict(32'h500, p));
    d = pop_dep();
    nchk++; if (d !== p + 1)
      $display("FAIL rw_unpaced_dep got %0d exp %0d", d, p + 1); else npass++;
    flush();
  endtask

  task automatic test_reset_send();
    int p, d, w;
    bit hs;
    s_axis_tdata = '1;
    s_axis_tkeep = '1;
    s_axis_tuser = {64'h0, 32'h0, 32'h40};
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    w = 0;
    hs = 1'b0;
    while (!hs && w < LIMIT) begin
      @(negedge clk);
      hs = (s_axis_tready === 1'b1);
      @(posedge clk); #1;
      w++;
    end
    nchk++; if (!hs)
      $display("FAIL rs_first_beat waited %0d exp <%0d", w, LIMIT);
    else npass++;
    m_axis_tready = 1'b0;
    s_axis_tdata = '0;
    repeat (2) begin @(posedge clk); #1; end
    nchk++; if (m_axis_tvalid !== 1'b1)
      $display("FAIL rs_mid_send got tvalid %b exp 1", m_axis_tvalid);
    else npass++;
    axis_reset = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    axis_reset = 1'b0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    nchk++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0)
      $display("FAIL rs_after_reset got tvalid %b tready %b exp 0 0",
               m_axis_tvalid, s_axis_tready); else npass++;
    s_axis_tvalid = 1'b0;
    mdl_reset();
    flush();
    send_pkt(32'h600, 1, 0, p);
    void'(predict(32'h600, p));
    d = pop_dep();
    nchk++; if (d !== p + 1)
      $display("FAIL rs_unpaced_dep got %0d exp %0d", d, p + 1); else npass++;
    flush();
  endtask

  task automatic test_wrap();
    int p0, p1, d0, d1;
    do_reset();
    send_pkt(32'hFFFF_FFFF, 1, 0, p0);
    void'(predict(32'hFFFF_FFFF, p0));
    send_pkt(32'h0000_0001, 2, 0, p1);
    void'(predict(32'h0000_0001, p1));
    d0 = pop_dep();
    d1 = pop_dep();
    nchk++; if (d0 !== p0 + 1)
      $display("FAIL wrap_first_dep got %0d exp %0d", d0, p0 + 1); else npass++;
    nchk++; if (d1 - d0 !== 2 * CPU)
      $display("FAIL wrap_gap got %0d exp %0d", d1 - d0, 2 * CPU); else npass++;
    flush();
  endtask

  task automatic test_random();
    int p, d, nb, gap;
    longint e;
    logic [31:0] ts;
    bit ok;
    for (int n = 0; n < 12; n++) begin
      nb = $urandom_range(1, 4);
      gap = $urandom_range(0, 400);
      ts = ($urandom_range(0, 5) == 0) ? 32'h0
         : m_tsprev + 32'($urandom_range(0, 3));
      send_pkt(ts, nb, gap, p);
      e = predict(ts, p);
      d = pop_dep();
      nchk++; if (longint'(d) !== e)
        $display("FAIL rand%0d_dep ts %h got %0d exp %0d", n, ts, d, e);
      else npass++;
      ok = (got_d.size() == nb);
      for (int b = 0; b < nb && ok; b++)
        ok = got_d[b] === exp_d[b] && got_u[b] === {96'h0, exp_u[b]} &&
             got_l[b] === exp_l[b];
      nchk++; if (!ok)
        $display("FAIL rand%0d_beats got %0d beats exp %0d matching",
                 n, got_d.size(), nb);
      else npass++;
      flush();
    end
    nchk++; if (late_cnt !== 32'(m_late))
      $display("FAIL rand_late_cnt got %0d exp %0d", late_cnt, m_late);
    else npass++;
    nchk++; if (pkt_cnt !== 32'(m_pkts))
      $display("FAIL rand_pkt_cnt got %0d exp %0d", pkt_cnt, m_pkts);
    else npass++;
  endtask

  initial begin
    axis_reset = 1'b1;
    replay_en = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tuser = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    mdl_reset();
    test_reset();
    test_paced();
    test_zero_ts();
    test_late();
    test_backpressure();
    test_reset_wait();
    test_reset_send();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
